// File: rtl/ddr3_fifo_pkg.sv
// Shared defaults and width helpers for the DDR3 write-side FIFO packer.
package ddr3_fifo_pkg;

  localparam int DEF_RATIO   = 4;
  localparam int DEF_TIMEOUT = 16;

  function automatic int lane_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int keep_w(input int ratio);
    return ratio;
  endfunction

endpackage

// File: rtl/wr_packer_obuf.sv
// One-entry output holding register between the packer and the FIFO write port.
module wr_packer_obuf #(
  parameter int DW = 128,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [KW-1:0] load_keep,
  input  logic          full,
  output logic          vld,
  output logic [DW-1:0] data,
  output logic [KW-1:0] keep,
  output logic          wr_en,
  output logic          ready
);

  logic          vld_p1;
  logic [DW-1:0] data_p1;
  logic [KW-1:0] keep_p1;

  // Stage p1: held word; a load may coincide with the drain of the previous word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      keep_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
      keep_p1 <= load_keep;
    end else if (vld_p1 && !full) begin
      vld_p1  <= 1'b0;
    end
  end

  assign vld   = vld_p1;
  assign data  = data_p1;
  assign keep  = keep_p1;
  // A word held across reset is discarded, so it must not reach the FIFO in that cycle.
  assign wr_en = vld_p1 && !full && !rst;
  assign ready = !(vld_p1 && full);

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs RATIO input beats into one FIFO word with a lane keep mask.
// Optional idle-timeout flush of partial words: define FIFO_WR_PACKER_TIMEOUT_EN.
module fifo_wr_packer
  import ddr3_fifo_pkg::*;
#(
  parameter  int DW_IN   = 32,
  parameter  int RATIO   = DEF_RATIO,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int DW_OUT  = DW_IN * RATIO
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DW_IN-1:0]  i_data,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [DW_OUT-1:0] o_din,
  output logic [RATIO-1:0]  o_keep,
  input  logic              i_full,
  output logic              o_busy
);

  localparam int LANE_W = lane_idx_w(RATIO);
  localparam int KEEP_W = keep_w(RATIO);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_wr_packer: RATIO must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [LANE_W-1:0] lane_cnt_p0;
  logic [DW_OUT-1:0] acc_p0;
  logic [KEEP_W-1:0] keep_p0;

  logic              accept;
  logic              last_lane;
  logic              complete;
  logic              flush;
  logic              load;
  logic              out_vld;
  logic [DW_OUT-1:0] acc_ins;
  logic [KEEP_W-1:0] keep_ins;
  logic [DW_OUT-1:0] load_data;
  logic [KEEP_W-1:0] load_keep;

  assign accept    = i_valid && o_ready;
  assign last_lane = (lane_cnt_p0 == LANE_W'(RATIO - 1));
  assign complete  = accept && (last_lane || i_last);
  assign load      = complete || flush;

  // The completing beat is merged combinationally so the word lands in the
  // output register on the same edge that accepts it.
  always_comb begin
    acc_ins  = acc_p0;
    keep_ins = keep_p0;
    acc_ins[int'(lane_cnt_p0) * DW_IN +: DW_IN] = i_data;
    keep_ins[lane_cnt_p0] = 1'b1;
  end

  assign load_data = complete ? acc_ins  : acc_p0;
  assign load_keep = complete ? keep_ins : keep_p0;

  // Stage p0: lane accumulator; cleared on every word hand-off so unfilled lanes read zero
  always_ff @(posedge wr_clk) begin
    if (rst || load) begin
      lane_cnt_p0 <= '0;
      acc_p0      <= '0;
      keep_p0     <= '0;
    end else if (accept) begin
      lane_cnt_p0 <= lane_cnt_p0 + LANE_W'(1);
      acc_p0      <= acc_ins;
      keep_p0     <= keep_ins;
    end
  end

`ifdef FIFO_WR_PACKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_p0;
  logic            idle;

  assign idle  = (lane_cnt_p0 != '0) && !accept;
  // The current idle cycle is the TIMEOUT-th one; saturating holds a deferred flush.
  assign flush = idle && (to_cnt_p0 >= TO_W'(TIMEOUT - 1)) && o_ready;

  always_ff @(posedge wr_clk) begin
    if (rst || accept || flush) begin
      to_cnt_p0 <= '0;
    end else if (idle && (to_cnt_p0 < TO_W'(TIMEOUT - 1))) begin
      to_cnt_p0 <= to_cnt_p0 + TO_W'(1);
    end
  end
`else
  assign flush = 1'b0;
`endif

  wr_packer_obuf #(
    .DW (DW_OUT),
    .KW (KEEP_W)
  ) u_obuf (
    .clk       (wr_clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .full      (i_full),
    .vld       (out_vld),
    .data      (o_din),
    .keep      (o_keep),
    .wr_en     (o_wr_en),
    .ready     (o_ready)
  );

  assign o_busy = (lane_cnt_p0 != '0) || out_vld;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed and randomized bench for fifo_wr_packer against a beat-list reference model.
module tb_fifo_wr_packer;

  localparam int DW_IN   = 32;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 16;
  localparam int DW_OUT  = DW_IN * RATIO;

  logic              wr_clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic [DW_IN-1:0]  i_data;
  logic              i_last;
  logic              i_full;
  logic              o_ready;
  logic              o_wr_en;
  logic [DW_OUT-1:0] o_din;
  logic [RATIO-1:0]  o_keep;
  logic              o_busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: beats of the word being collected, and the word awaiting the FIFO.
  logic [DW_IN-1:0]        part[$];
  bit                      m_pend = 1'b0;
  logic [DW_OUT-1:0]       m_din  = '0;
  logic [RATIO-1:0]        m_keep = '0;
  int                      m_idle = 0;
  logic [DW_OUT+RATIO-1:0] wlog[$];

  always #5 wr_clk = ~wr_clk;

  fifo_wr_packer #(
    .DW_IN   (DW_IN),
    .RATIO   (RATIO),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wr_clk  (wr_clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_wr_en (o_wr_en),
    .o_din   (o_din),
    .o_keep  (o_keep),
    .i_full  (i_full),
    .o_busy  (o_busy)
  );

  task automatic chkw(input string tag, input logic [DW_OUT-1:0] obs, input logic [DW_OUT-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_close();
    m_din  = '0;
    m_keep = '0;
    for (int k = 0; k < part.size(); k++) begin
      m_din[k*DW_IN +: DW_IN] = part[k];
      m_keep[k] = 1'b1;
    end
    m_pend = 1'b1;
    part.delete();
    m_idle = 0;
  endtask

  // One clock: drive, check outputs against the model, then advance the model.
  task automatic cyc(input bit v, input logic [DW_IN-1:0] d, input bit l, input bit f, input bit r);
    bit rdy;
    bit wr;
    bit acc;
    @(negedge wr_clk);
    i_valid = v;
    i_data  = d;
    i_last  = l;
    i_full  = f;
    rst     = r;
    #1;
    rdy = !(m_pend && f);
    wr  = m_pend && !f && !r;
    chk1("o_ready", o_ready, rdy);
    chk1("o_wr_en", o_wr_en, wr);
    chk1("o_busy", o_busy, (part.size() != 0) || m_pend);
    if (m_pend) begin
      chkw("o_din", o_din, m_din);
      chkw("o_keep", DW_OUT'(o_keep), DW_OUT'(m_keep));
    end
    if (o_wr_en === 1'b1) wlog.push_back({o_keep, o_din});
    @(posedge wr_clk);
    if (r) begin
      part.delete();
      m_pend = 1'b0;
      m_idle = 0;
      return;
    end
    acc = v && rdy;
    if (wr) m_pend = 1'b0;
    if (acc) begin
      part.push_back(d);
      m_idle = 0;
      if (part.size() == RATIO || l) model_close();
    end
`ifdef FIFO_WR_PACKER_TIMEOUT_EN
    else if (part.size() != 0) begin
      if (m_idle < TIMEOUT) m_idle++;
      if (m_idle >= TIMEOUT && rdy) model_close();
    end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int first_wr;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_full  = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    rst = 1'b0;
    #1;
    chk1("reset_wr_en", o_wr_en, 1'b0);
    chkw("reset_din", o_din, '0);
    chkw("reset_keep", DW_OUT'(o_keep), '0);
    chk1("reset_ready", o_ready, 1'b1);
    chk1("reset_busy", o_busy, 1'b0);

    // Two full words back to back
    wlog.delete();
    for (int k = 1; k <= 8; k++) cyc(1'b1, DW_IN'(k), 1'b0, 1'b0, 1'b0);
    idle(2);
    chkw("full_words_count", DW_OUT'(wlog.size()), DW_OUT'(2));
    if (wlog.size() == 2) begin
      chkw("word0_din", wlog[0][DW_OUT-1:0], 128'h00000004_00000003_00000002_00000001);
      chkw("word0_keep", DW_OUT'(wlog[0][DW_OUT +: RATIO]), DW_OUT'(4'hF));
      chkw("word1_din", wlog[1][DW_OUT-1:0], 128'h00000008_00000007_00000006_00000005);
      chkw("word1_keep", DW_OUT'(wlog[1][DW_OUT +: RATIO]), DW_OUT'(4'hF));
    end

    // Partial word closed by i_last
    wlog.delete();
    cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    idle(2);
    chkw("last_count", DW_OUT'(wlog.size()), DW_OUT'(1));
    if (wlog.size() == 1) begin
      chkw("last_din", wlog[0][DW_OUT-1:0], 128'h00000000_0000000C_0000000B_0000000A);
      chkw("last_keep", DW_OUT'(wlog[0][DW_OUT +: RATIO]), DW_OUT'(4'h7));
    end

    // FIFO full for 5 cycles with a word pending; offered beats must be refused
    wlog.delete();
    for (int k = 0; k < 4; k++) cyc(1'b1, DW_IN'(32'h11 + k), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
      chkw("full_hold_din", o_din, 128'h00000014_00000013_00000012_00000011);
    end
    chkw("full_no_write", DW_OUT'(wlog.size()), '0);
    idle(3);
    chkw("full_release_count", DW_OUT'(wlog.size()), DW_OUT'(1));

    // Reset in the middle of a word
    wlog.delete();
    cyc(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge wr_clk);
    #1;
    chk1("mid_reset_busy", o_busy, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, DW_IN'(32'h31 + k), 1'b0, 1'b0, 1'b0);
    idle(2);
    chkw("mid_reset_count", DW_OUT'(wlog.size()), DW_OUT'(1));
    if (wlog.size() == 1)
      chkw("mid_reset_din", wlog[0][DW_OUT-1:0], 128'h00000034_00000033_00000032_00000031);

    // Single beat then idle: flushed only when the timeout feature is built in
    wlog.delete();
    first_wr = 0;
    cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (first_wr == 0 && wlog.size() != 0) first_wr = i;
    end
`ifdef FIFO_WR_PACKER_TIMEOUT_EN
    chkw("timeout_idx", DW_OUT'(first_wr), DW_OUT'(TIMEOUT + 1));
    if (wlog.size() == 1) begin
      chkw("timeout_din", wlog[0][DW_OUT-1:0], 128'h55);
      chkw("timeout_keep", DW_OUT'(wlog[0][DW_OUT +: RATIO]), DW_OUT'(4'h1));
    end
`else
    chkw("no_timeout_write", DW_OUT'(wlog.size()), '0);
`endif

    // Randomized traffic with back-pressure
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, DW_IN'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) == 0, 1'b0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 SHALL have parameter DW_IN, default 32, input beat width.
REQ-002 SHALL have parameter RATIO, default 4, beats per FIFO word, power of two, ≥2.
REQ-003 SHALL have parameter TIMEOUT, default 16, idle cycles before partial flush, ≥1.
REQ-004 SHALL have derived localparam DW_OUT = DW_IN*RATIO, the width of the downstream FIFO word.
REQ-005 SHALL have port wr_clk, input, 1, the single clock; one clock, reset synchronous active-high.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports i_valid, input, 1; i_data, input, DW_IN; i_last, input, 1 (input beat, valid/ready).
REQ-008 SHALL have port o_ready, output, 1, beat accepted when i_valid && o_ready.
REQ-009 SHALL have ports o_wr_en, output, 1, and o_din, output, DW_OUT, driving the FIFO write port.
REQ-010 SHALL have port o_keep, output, RATIO, per-lane valid mask accompanying o_din.
REQ-011 SHALL have port i_full, input, 1, from the FIFO o_full.
REQ-012 SHALL have port o_busy, output, 1, high while any beat is held internally.

Function
REQ-013 SHALL place accepted beat k of a word in lane k (o_din[k*DW_IN +: DW_IN]), lane 0 at LSB.
REQ-014 SHALL use a lane counter of log2(RATIO) bits, wrapping RATIO-1 → 0 on word completion.
REQ-015 SHALL complete a word on acceptance of the RATIO-th beat, or of any beat with i_last=1.
REQ-016 SHALL zero unfilled lanes of a partial word and clear their o_keep bits.
REQ-017 SHALL move a completed word into a one-entry output register (out_vld) in the cycle after the completing beat is accepted.
REQ-018 SHALL drive o_wr_en = out_vld && !i_full; o_wr_en never asserts while i_full=1.
REQ-019 SHALL drive o_ready = !(out_vld && i_full); while out_vld=1 and i_full=0, a completing beat is accepted and the output register reloads in the same cycle as the drain.
REQ-020 SHALL hold o_din/o_keep stable while out_vld=1 and i_full=1.
REQ-021 SHALL give a latency of exactly 1 cycle from completing-beat acceptance to o_wr_en when i_full=0.
REQ-022 SHALL sustain 1 beat/cycle with no bubbles while i_full=0.
REQ-023 SHALL drive o_busy = (lane counter != 0) || out_vld.

Reset
REQ-024 SHALL, on rst=1 at a wr_clk edge, clear lane counter, accumulator, keep mask, out_vld and timeout counter.
REQ-025 SHALL give reset output values: o_wr_en=0, o_din=0, o_keep=0, o_ready=1, o_busy=0.
REQ-026 SHALL discard a partial word or pending output when reset asserts mid-operation; no write occurs in the reset cycle.

Configuration
REQ-027 SHALL, with macro FIFO_WR_PACKER_TIMEOUT_EN defined, count cycles with lane counter != 0 and no accepted beat, and at count == TIMEOUT flush the partial word as if i_last had been seen; the counter clears on any accepted beat or flush.
REQ-028 SHALL, without FIFO_WR_PACKER_TIMEOUT_EN, omit the timeout counter logic, so that a partial word is emitted only on i_last.
REQ-029 SHALL, with FIFO_WR_PACKER_TIMEOUT_EN, defer a timeout flush while out_vld && i_full and perform it on the first cycle the output register frees.

Structure
REQ-030 SHALL place the lane-index and keep-mask width helper constants and the default RATIO/TIMEOUT in shared package ddr3_fifo_pkg.
REQ-031 SHALL instantiate one sub-module, wr_packer_obuf (one-entry output holding register with valid/full handshake); the rest is flat.

Verification
REQ-032 SHALL cover: 8 beats 0x1..0x8, i_full=0 → o_wr_en at 2 cycles, o_din=0x…4_3_2_1 then 0x…8_7_6_5, o_keep=4'hF each.
REQ-033 SHALL cover: 3 beats 0xA,0xB,0xC with i_last on 0xC → one write, lanes 0–2 = A,B,C, lane 3 = 0, o_keep=4'h7.
REQ-034 SHALL cover: i_full=1 held 5 cycles with a word pending → o_wr_en=0, o_ready=0, o_din stable; after i_full=0, a single write occurs the next cycle.
REQ-035 SHALL cover: rst pulsed after 2 beats of a word → o_busy=0, no write; the next 4 beats produce one clean word.
REQ-036 SHALL cover, with FIFO_WR_PACKER_TIMEOUT_EN and TIMEOUT=16: 1 beat 0x55 then idle → write at idle cycle 16+1 with o_keep=4'h1; without the macro, no write.
